bitmap_scanx: RTL and testbench

Parameterised sequential bitmap scanner: captures an INW-bit bitmap and emits, one per accepted handshake, the index of every bit equal to VALUE, in LSB-first or MSB-first order. It extends the single-shot combinational bitmap encoder into a multi-hit enumerator. Typical uses are channel-alarm walkers and per-tributary service scheduling, where every flagged channel must be visited, not just one. Outputs are registered, with valid/ready flow control and a done pulse per bitmap.

---
 rtl/bitmap_scanx.sv | 112 +++++++++++
 tb/tb_bitmap_scanx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_scanx.sv
// Sequential bitmap scanner: enumerates the index of every bit equal to VALUE, one per handshake.
// First index two cycles after load; oidx/ovalid hold while ordy is low; done pulses once the mask is empty.
module bitmap_scanx #(
  parameter int   INW   = 256,
  parameter int   OUTW  = 8,
  parameter logic VALUE = 1'b1,
  parameter bit   MSBF  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ld,
  input  logic [INW-1:0]  ldmap,
  input  logic            abort,
  output logic            busy,
  output logic            ovalid,
  output logic [OUTW-1:0] oidx,
  input  logic            ordy,
  output logic            done,
  output logic [OUTW:0]   hits
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nxt;
  logic [INW-1:0]  mask;
  logic [INW-1:0]  pick;
  logic [OUTW-1:0] sel;
  logic            any;
  logic            accept;
  logic            advance;
  logic            handshake;

  // Last match in the loop wins, so the iteration direction sets the priority.
  always_comb begin
    sel  = '0;
    pick = '0;
    for (int i = 0; i < INW; i++) begin
      if (MSBF) begin
        if (mask[i]) begin
          sel     = OUTW'(i);
          pick    = '0;
          pick[i] = 1'b1;
        end
      end else begin
        if (mask[INW-1-i]) begin
          sel           = OUTW'(INW-1-i);
          pick          = '0;
          pick[INW-1-i] = 1'b1;
        end
      end
    end
  end

  assign any       = |mask;
  assign busy      = (state == SCAN);
  assign accept    = ld & ~busy & ~abort;
  assign advance   = busy & (~ovalid | ordy) & ~abort;
  assign handshake = ovalid & ordy;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SCAN;
      SCAN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (advance && !any) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mask   <= '0;
      ovalid <= 1'b0;
      oidx   <= '0;
      done   <= 1'b0;
      hits   <= '0;
    end else begin
      done <= 1'b0;
      if (handshake) hits <= hits + 1'b1;
      if (abort) begin
        mask   <= '0;
        ovalid <= 1'b0;
      end else if (accept) begin
        mask <= VALUE ? ldmap : ~ldmap;
        hits <= '0;
      end else if (advance) begin
        if (any) begin
          oidx   <= sel;
          ovalid <= 1'b1;
          mask   <= mask & ~pick;
        end else begin
          ovalid <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitmap_scanx.sv
// Directed bench: three scanner variants (LSB-first, MSB-first, clear-bit) driven from shared stimulus.
module tb_bitmap_scanx;

  logic            clk = 1'b0;
  logic            rst_;
  logic            ld;
  logic [7:0]      ldmap;
  logic            abort;
  logic            ordy;
  logic [2:0]      busy;
  logic [2:0]      ovalid;
  logic [2:0]      done;
  logic [2:0][2:0] oidx;
  logic [2:0][3:0] hits;

  int n_cmp = 0;
  int n_err = 0;
  int seq_a6 [3][4];

  always #5 clk = ~clk;

  bitmap_scanx #(.INW(8), .OUTW(3), .VALUE(1'b1), .MSBF(1'b0)) u_lsb (
    .clk(clk), .rst_(rst_), .ld(ld), .ldmap(ldmap), .abort(abort), .busy(busy[0]),
    .ovalid(ovalid[0]), .oidx(oidx[0]), .ordy(ordy), .done(done[0]), .hits(hits[0]));
  bitmap_scanx #(.INW(8), .OUTW(3), .VALUE(1'b1), .MSBF(1'b1)) u_msb (
    .clk(clk), .rst_(rst_), .ld(ld), .ldmap(ldmap), .abort(abort), .busy(busy[1]),
    .ovalid(ovalid[1]), .oidx(oidx[1]), .ordy(ordy), .done(done[1]), .hits(hits[1]));
  bitmap_scanx #(.INW(8), .OUTW(3), .VALUE(1'b0), .MSBF(1'b0)) u_clr (
    .clk(clk), .rst_(rst_), .ld(ld), .ldmap(ldmap), .abort(abort), .busy(busy[2]),
    .ovalid(ovalid[2]), .oidx(oidx[2]), .ordy(ordy), .done(done[2]), .hits(hits[2]));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_st(input string tag, input int n, input int b, input int v, input int d);
    chk($sformatf("%s[%0d].busy", tag, n), int'(busy[n]), b);
    chk($sformatf("%s[%0d].ovalid", tag, n), int'(ovalid[n]), v);
    chk($sformatf("%s[%0d].done", tag, n), int'(done[n]), d);
  endtask

  task automatic exp_idx(input string tag, input int n, input int ix);
    chk($sformatf("%s[%0d].oidx", tag, n), int'(oidx[n]), ix);
  endtask

  task automatic exp_hits(input string tag, input int n, input int h);
    chk($sformatf("%s[%0d].hits", tag, n), int'(hits[n]), h);
  endtask

  // Loads 8'hA6 with ordy high and checks the full four-index scan on every variant.
  task automatic run_a6(input string tag);
    ld = 1'b1; ldmap = 8'hA6; ordy = 1'b1;
    tick();
    ld = 1'b0;
    for (int n = 0; n < 3; n++) exp_st({tag, ".t1"}, n, 1, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 3; n++) begin
        exp_st($sformatf("%s.k%0d", tag, k), n, 1, 1, 0);
        exp_idx($sformatf("%s.k%0d", tag, k), n, seq_a6[n][k]);
      end
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      exp_st({tag, ".end"}, n, 0, 0, 1);
      exp_hits({tag, ".end"}, n, 4);
    end
  endtask

  initial begin
    int k;
    seq_a6[0] = '{1, 2, 5, 7};
    seq_a6[1] = '{7, 5, 2, 1};
    seq_a6[2] = '{0, 3, 4, 6};
    rst_ = 1'b0; ld = 1'b0; ldmap = 8'h00; abort = 1'b0; ordy = 1'b0;
    tick(); tick();
    for (int n = 0; n < 3; n++) begin
      exp_st("rst", n, 0, 0, 0);
      exp_idx("rst", n, 0);
      exp_hits("rst", n, 0);
    end
    rst_ = 1'b1;
    tick();

    run_a6("a6");

    // Empty map loaded in the done cycle; the clear-bit variant sees all ones.
    ld = 1'b1; ldmap = 8'h00;
    tick();
    ld = 1'b0;
    for (int n = 0; n < 3; n++) exp_st("z.t1", n, 1, 0, 0);
    tick();
    for (int c = 0; c < 8; c++) begin
      exp_st($sformatf("z.c%0d", c), 0, 0, 0, (c == 0) ? 1 : 0);
      exp_st($sformatf("z.c%0d", c), 1, 0, 0, (c == 0) ? 1 : 0);
      exp_st($sformatf("z.c%0d", c), 2, 1, 1, 0);
      exp_idx($sformatf("z.c%0d", c), 2, c);
      tick();
    end
    exp_st("z.end", 2, 0, 0, 1);
    exp_hits("z.end", 2, 8);
    exp_hits("z.end", 0, 0);
    exp_hits("z.end", 1, 0);

    ld = 1'b1; ldmap = 8'hFF;
    tick();
    ld = 1'b0;
    for (int n = 0; n < 3; n++) exp_st("f.t1", n, 1, 0, 0);
    tick();
    for (int c = 0; c < 8; c++) begin
      exp_st($sformatf("f.c%0d", c), 0, 1, 1, 0);
      exp_idx($sformatf("f.c%0d", c), 0, c);
      exp_st($sformatf("f.c%0d", c), 1, 1, 1, 0);
      exp_idx($sformatf("f.c%0d", c), 1, 7 - c);
      exp_st($sformatf("f.c%0d", c), 2, 0, 0, (c == 0) ? 1 : 0);
      tick();
    end
    exp_st("f.end", 0, 0, 0, 1);
    exp_st("f.end", 1, 0, 0, 1);
    exp_hits("f.end", 0, 8);
    exp_hits("f.end", 1, 8);
    exp_hits("f.end", 2, 0);
    tick();

    // Backpressure for three cycles on the second index, with a stray ld in the middle.
    ld = 1'b1; ldmap = 8'hA6; ordy = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    for (int c = 0; c < 7; c++) begin
      k = (c == 0) ? 0 : (c <= 4) ? 1 : c - 3;
      for (int n = 0; n < 3; n++) begin
        exp_st($sformatf("bp.c%0d", c), n, 1, 1, 0);
        exp_idx($sformatf("bp.c%0d", c), n, seq_a6[n][k]);
      end
      ordy = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
      ld = (c == 1) ? 1'b1 : 1'b0;
      ldmap = 8'hFF;
      tick();
    end
    ld = 1'b0;
    for (int n = 0; n < 3; n++) begin
      exp_st("bp.end", n, 0, 0, 1);
      exp_hits("bp.end", n, 4);
    end
    tick();
    for (int n = 0; n < 3; n++) exp_st("bp.post", n, 0, 0, 0);

    // Abort together with ld after two handshakes.
    ld = 1'b1; ldmap = 8'hA6; ordy = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 3; n++) exp_idx($sformatf("ab.c%0d", c), n, seq_a6[n][c]);
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      exp_st("ab.pre", n, 1, 1, 0);
      exp_idx("ab.pre", n, seq_a6[n][2]);
    end
    ordy = 1'b0; abort = 1'b1; ld = 1'b1; ldmap = 8'hFF;
    tick();
    abort = 1'b0; ld = 1'b0;
    for (int n = 0; n < 3; n++) begin
      exp_st("ab.k1", n, 0, 0, 0);
      exp_hits("ab.k1", n, 2);
    end
    tick();
    for (int n = 0; n < 3; n++) exp_st("ab.k2", n, 0, 0, 0);
    ld = 1'b1; ldmap = 8'h81; ordy = 1'b1;
    tick();
    ld = 1'b0;
    for (int n = 0; n < 3; n++) begin
      exp_st("ab.new1", n, 1, 0, 0);
      exp_hits("ab.new1", n, 0);
    end
    tick();
    exp_idx("ab.new2", 0, 0);
    exp_idx("ab.new2", 1, 7);
    exp_idx("ab.new2", 2, 1);
    tick();
    exp_idx("ab.new3", 0, 7);
    exp_idx("ab.new3", 1, 0);
    exp_idx("ab.new3", 2, 2);
    for (int c = 0; c < 8; c++) tick();
    for (int n = 0; n < 3; n++) exp_st("ab.drain", n, 0, 0, 0);

    // Asynchronous reset mid-scan, then a clean rerun.
    ld = 1'b1; ldmap = 8'hA6; ordy = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    for (int n = 0; n < 3; n++) exp_idx("rs.k0", n, seq_a6[n][0]);
    tick();
    rst_ = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) begin
      exp_st("rs.async", n, 0, 0, 0);
      exp_idx("rs.async", n, 0);
      exp_hits("rs.async", n, 0);
    end
    tick();
    rst_ = 1'b1;
    run_a6("rs.rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
